data_mem_be: RTL and testbench
==============================

// Module: data_mem_be
// PURPOSE
//  Parametrised single-port data memory for the pipeline MEM stage.
//  Adds byte-lane write enables, a registered read with valid strobe, and a
//  reset-time clear FSM that fills every word before accepting requests.
//  Flags out-of-range accesses. Sits between the EX/MEM register and MEM/WB.
// PARAMETERS
//  DATA_W    16      word width in bits; must be a multiple of 8
//  ADDR_W    8       address width
//  DEPTH     256     implemented words; must be <= 2**ADDR_W
//  FILL_VAL  0       value written to every word during INIT
// PORTS
//  clk    in   1          clock, all logic on rising edge
//  rst    in   1          synchronous reset, active-high
//  req    in   1          access request, sampled when ready=1
//  we     in   1          1 = write, 0 = read
//  be     in   DATA_W/8   byte enables; be[i] covers wdata[8i+7:8i]
//  addr   in   ADDR_W     word address
//  wdata  in   DATA_W     write data
//  ready  out  1          1 = RUN state, requests accepted
//  rvalid out  1          1-cycle pulse: rdata holds read result
//  rdata  out  DATA_W     read data, held until next read completes
//  err    out  1          1-cycle pulse: accepted request had addr >= DEPTH
// BEHAVIOUR
//  - Reset values: ready=0, rvalid=0, rdata=0, err=0, state=INIT, init_ptr=0.
//  - Clock and reset:
//    - rst is sampled on the clock; if rst=1 at an edge, the reset values are
//      loaded and no request is accepted.
//    - rst asserted mid-operation aborts any access and restarts INIT at 0.
//  - FSM INIT:
//    - Each cycle writes FILL_VAL to mem[init_ptr], then init_ptr++.
//    - At init_ptr=DEPTH-1 the write completes and the FSM enters RUN next
//      cycle. INIT therefore lasts exactly DEPTH cycles after rst falls.
//    - ready=0 throughout INIT; req is ignored and produces no rvalid or err.
//  - FSM RUN:
//    - ready=1. The FSM stays in RUN until rst.
//    - An access is accepted when req=1 at an edge.
//  - Write (we=1, addr<DEPTH):
//    - Each byte lane with be[i]=1 is updated; lanes with be[i]=0 keep their
//      old value.
//    - be=0 is a legal no-op.
//    - No rvalid.
//  - Read (we=0, addr<DEPTH):
//    - rdata=mem[addr] and rvalid=1 on the edge after acceptance (latency 1).
//    - be is ignored.
//  - Back-to-back access to the same address:
//    - A read accepted the cycle after a write returns the written data.
//    - Reads may issue every cycle (one per clock).
//  - Out of range (addr>=DEPTH):
//    - A write changes nothing.
//    - A read returns rdata=0 with rvalid=1.
//    - Both pulse err=1 on the same edge rvalid would.
//  - rdata holds its value between reads; it is not cleared by writes.
// TESTING
//  1. rst=1 for 2 cycles, then 0 -> ready=0 for exactly DEPTH(256) cycles,
//     then ready=1; reads of addr 0, 1, 255 return 16'h0000.
//  2. Write addr 5 wdata=16'hABCD be=2'b11, then read 5 -> next cycle
//     rvalid=1, rdata=16'hABCD.
//  3. Write 16'h1234 be=2'b01 over 16'hABCD at addr 5, then read 5 ->
//     rdata=16'hAB34.
//  4. DEPTH=200: write addr 210, then read 210 -> err pulse on both accesses;
//     read gives rdata=0 with rvalid=1; word 210-DEPTH is untouched.
//  5. rst pulsed during a RUN read stream -> rvalid=0 on the next cycle,
//     ready=0 for DEPTH cycles; earlier data at addr 5 now reads FILL_VAL.
//  6. req=1 read during INIT -> no rvalid or err; the request is dropped.

Source files
------------

// File: rtl/data_mem_be.sv
// data_mem_be: byte-enable data memory with registered read, reset-time fill and range error flag
module data_mem_be #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH = 256,
    parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    typedef enum logic {INIT, RUN} state_t;
    state_t state;
    logic [IDX_W-1:0] init_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic in_range;
    logic [IDX_W-1:0] idx;
    // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_W
    assign in_range = {1'b0, addr} < DEPTH_L;
    assign idx = addr[IDX_W-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            init_ptr <= '0;
            ready <= 1'b0;
            rvalid <= 1'b0;
            rdata <= '0;
            err <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err <= 1'b0;
            if (state == INIT) begin
                init_ptr <= init_ptr + 1'b1;
                if (init_ptr == IDX_W'(DEPTH - 1)) begin
                    state <= RUN;
                    ready <= 1'b1;
                end
            end else if (req) begin
                err <= !in_range;
                if (!we) begin
                    rvalid <= 1'b1;
                    rdata <= in_range ? mem[idx] : '0;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                mem[init_ptr] <= FILL_VAL;
            else if (req && we && in_range)
                for (int i = 0; i < DATA_W / 8; i++)
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: drives a full-depth and a 200-word instance with shared stimulus, scoreboarded against array models
module tb_data_mem_be;
    localparam logic [15:0] FILL_B = 16'hC3A5;
    typedef struct packed {logic v; logic e; logic [15:0] d;} exp_t;

    logic clk, rst, req, we;
    logic [1:0] be;
    logic [7:0] addr;
    logic [15:0] wdata;
    logic a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
    logic [15:0] a_rdata, b_rdata;

    int n_checks = 0;
    int n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [15:0] ma [256];
    logic [15:0] mb [200];
    logic [15:0] last_a, last_b;

    data_mem_be dut_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .ready(a_ready), .rvalid(a_rvalid), .rdata(a_rdata), .err(a_err)
    );
    data_mem_be #(.DEPTH(200), .FILL_VAL(FILL_B)) dut_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .ready(b_ready), .rvalid(b_rvalid), .rdata(b_rdata), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t ea, eb;
        if (a_rvalid || a_err) begin
            if (qa.size() == 0) chk("a_unexpected_output", {a_rvalid, a_err}, 0);
            else begin
                ea = qa.pop_front();
                chk("a_rvalid", a_rvalid, ea.v);
                chk("a_err", a_err, ea.e);
                if (ea.v) chk("a_rdata", a_rdata, ea.d);
            end
        end
        if (b_rvalid || b_err) begin
            if (qb.size() == 0) chk("b_unexpected_output", {b_rvalid, b_err}, 0);
            else begin
                eb = qb.pop_front();
                chk("b_rvalid", b_rvalid, eb.v);
                chk("b_err", b_err, eb.e);
                if (eb.v) chk("b_rdata", b_rdata, eb.d);
            end
        end
    end

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] b);
        logic [15:0] mask;
        mask = {{8{b[1]}}, {8{b[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic acc(input logic w, input logic [1:0] b, input logic [7:0] a, input logic [15:0] d);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        @(posedge clk); #1;
        if (w) ma[a] = merge(ma[a], d, b);
        else begin
            qa.push_back('{1'b1, 1'b0, ma[a]});
            last_a = ma[a];
        end
        if (a < 200) begin
            if (w) mb[a] = merge(mb[a], d, b);
            else begin
                qb.push_back('{1'b1, 1'b0, mb[a]});
                last_b = mb[a];
            end
        end else begin
            qb.push_back('{!w, 1'b1, 16'h0000});
            if (!w) last_b = 16'h0000;
        end
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_and_init();
        int na, nb;
        rst = 1'b1; req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("reset_a_ready", a_ready, 0);
        chk("reset_a_rvalid", a_rvalid, 0);
        chk("reset_a_rdata", a_rdata, 0);
        chk("reset_a_err", a_err, 0);
        chk("reset_b_ready", b_ready, 0);
        chk("reset_b_rdata", b_rdata, 0);
        foreach (ma[i]) ma[i] = 16'h0000;
        foreach (mb[i]) mb[i] = FILL_B;
        rst = 1'b0;
        na = 0; nb = 0;
        for (int n = 1; n <= 300 && (na == 0 || nb == 0); n++) begin
            req = n <= 100; we = 1'b0; addr = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            if (na == 0 && a_ready) na = n;
            if (nb == 0 && b_ready) nb = n;
        end
        req = 1'b0;
        chk("init_len_a", na, 256);
        chk("init_len_b", nb, 200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 2'b00; addr = '0; wdata = '0;
        last_a = '0; last_b = '0;
        reset_and_init();
        acc(0, 2'b00, 8'd0, 16'h0);
        acc(0, 2'b00, 8'd1, 16'h0);
        acc(0, 2'b00, 8'd255, 16'h0);
        acc(1, 2'b11, 8'd5, 16'hABCD);
        acc(0, 2'b00, 8'd5, 16'h0);
        acc(1, 2'b01, 8'd5, 16'h1234);
        acc(0, 2'b10, 8'd5, 16'h0);
        acc(1, 2'b00, 8'd5, 16'hFFFF);
        acc(0, 2'b00, 8'd5, 16'h0);
        acc(1, 2'b11, 8'd210, 16'h5555);
        acc(0, 2'b00, 8'd210, 16'h0);
        acc(0, 2'b00, 8'd10, 16'h0);
        acc(1, 2'b11, 8'd199, 16'h7E57);
        acc(0, 2'b00, 8'd199, 16'h0);
        acc(0, 2'b00, 8'd200, 16'h0);
        idle(2);
        for (int k = 0; k < 400; k++) begin
            logic [7:0] a;
            a = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(190, 215));
            if ($urandom_range(0, 4) == 0) idle(1);
            acc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, 16'($urandom));
        end
        acc(1, 2'b11, 8'd3, 16'h9999);
        idle(2);
        chk("rdata_hold_a", a_rdata, last_a);
        chk("rdata_hold_b", b_rdata, last_b);
        acc(0, 2'b00, 8'd5, 16'h0);
        acc(0, 2'b00, 8'd6, 16'h0);
        rst = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        chk("rst_abort_a_rvalid", a_rvalid, 0);
        chk("rst_abort_b_rvalid", b_rvalid, 0);
        reset_and_init();
        acc(0, 2'b00, 8'd5, 16'h0);
        acc(0, 2'b00, 8'd199, 16'h0);
        idle(3);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
